config_loader: RTL and testbench

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader_if.sv | 9 +
 rtl/config_loader.sv | 101 ++++++++++
 tb/tb_config_loader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/config_loader_if.sv
// config_loader_if: byte-stream configuration bus (data/valid/ready plus abort).
interface config_loader_if;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_abort;
    modport master (output cfg_data, cfg_valid, cfg_abort, input cfg_ready);
    modport slave  (input cfg_data, cfg_valid, cfg_abort, output cfg_ready);
endinterface

// File: rtl/config_loader.sv
// config_loader: framed byte loader committing a 24-bit tile config plus use_ff atomically.
// Define CFG_LOADER_CHECKSUM_EN to require a trailing XOR check byte (6-byte frames).
module config_loader (
    input  logic                  clk,
    input  logic                  rst_n,
    config_loader_if.slave        cfg,
    output logic [23:0]           config_bits,
    output logic                  use_ff,
    output logic                  cfg_loaded,
    output logic                  cfg_done,
    output logic                  cfg_error
);
    typedef enum logic [2:0] {
        IDLE,
        DATA,
        FLAGS,
`ifdef CFG_LOADER_CHECKSUM_EN
        CHECK,
`endif
        COMMIT
    } state_t;
    state_t      state, state_nx;
    logic [1:0]  cnt;
    logic [23:0] shadow;
    logic        ready, acc, commit, bad, ff_src;
`ifdef CFG_LOADER_CHECKSUM_EN
    logic        shadow_ff;
    logic [7:0]  chk_x;
    assign chk_x  = shadow[7:0] ^ shadow[15:8] ^ shadow[23:16] ^ {7'b0, shadow_ff};
    assign ff_src = shadow_ff;
`else
    assign ff_src = cfg.cfg_data[0];
`endif
    assign acc           = cfg.cfg_valid && ready;
    assign cfg.cfg_ready = ready;
    assign cfg_done      = state == COMMIT;
    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        bad      = 1'b0;
        if (cfg.cfg_abort)
            state_nx = IDLE;
        else
            case (state)
                IDLE:   if (acc && cfg.cfg_data == 8'hA5) state_nx = DATA;
                DATA:   if (acc && cnt == 2'd2) state_nx = FLAGS;
                FLAGS:  if (acc) begin
                            bad = |cfg.cfg_data[7:1];
`ifdef CFG_LOADER_CHECKSUM_EN
                            state_nx = bad ? IDLE : CHECK;
`else
                            commit   = !bad;
                            state_nx = bad ? IDLE : COMMIT;
`endif
                        end
`ifdef CFG_LOADER_CHECKSUM_EN
                CHECK:  if (acc) begin
                            bad      = cfg.cfg_data != chk_x;
                            commit   = !bad;
                            state_nx = bad ? IDLE : COMMIT;
                        end
`endif
                default: state_nx = IDLE;
            endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            shadow      <= 24'd0;
            ready       <= 1'b0;
            cfg_error   <= 1'b0;
            config_bits <= 24'd0;
            use_ff      <= 1'b0;
            cfg_loaded  <= 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
            shadow_ff   <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            ready     <= state_nx != COMMIT;
            cfg_error <= bad;
            cnt       <= (state == DATA && state_nx == DATA) ? cnt + {1'b0, acc} : 2'd0;
            if (cfg.cfg_abort)
                shadow <= 24'd0;
            else if (acc && state == DATA)
                shadow[{cnt, 3'b000} +: 8] <= cfg.cfg_data;
`ifdef CFG_LOADER_CHECKSUM_EN
            if (cfg.cfg_abort)
                shadow_ff <= 1'b0;
            else if (acc && state == FLAGS)
                shadow_ff <= cfg.cfg_data[0];
`endif
            if (commit) begin
                config_bits <= shadow;
                use_ff      <= ff_src;
                cfg_loaded  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: table-driven frame vectors plus hand sequences for abort, streaming and reset.
module tb_config_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] config_bits;
    logic        use_ff, cfg_loaded, cfg_done, cfg_error;
    int          checks = 0, errors = 0;
    int          done_cnt = 0, err_cnt = 0, low_cnt = 0;
    logic        win = 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
    localparam int FL = 6;
`else
    localparam int FL = 5;
`endif
    config_loader_if bus ();
    config_loader dut (
        .clk(clk), .rst_n(rst_n), .cfg(bus.slave),
        .config_bits(config_bits), .use_ff(use_ff), .cfg_loaded(cfg_loaded),
        .cfg_done(cfg_done), .cfg_error(cfg_error)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (cfg_done) done_cnt++;
        if (cfg_error) err_cnt++;
        if (win && !bus.cfg_ready) low_cnt++;
    end
    // b holds the frame bytes first-byte-first from bit 63 down; checksum covers the last four
    typedef struct packed {
        logic [3:0]  n;
        logic [63:0] b;
        logic        bad_chk;
        logic [23:0] e_bits;
        logic        e_ff;
        logic [1:0]  e_done;
        logic [1:0]  e_err;
    } vec_t;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!bus.cfg_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cfg_ready) chk("ready timeout", 32'(bus.cfg_ready), 32'd1);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = b;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask
    task automatic frame_bytes(input vec_t v, inout logic [7:0] q[$]);
        logic [7:0] x = 8'd0;
        for (int i = 0; i < int'(v.n); i++) begin
            logic [7:0] bi = v.b[63 - 8*i -: 8];
            if (i >= int'(v.n) - 4) x ^= bi;
            q.push_back(bi);
        end
`ifdef CFG_LOADER_CHECKSUM_EN
        q.push_back(x ^ {7'b0, v.bad_chk});
`endif
    endtask
    task automatic apply(input vec_t v, input string name);
        int d0 = done_cnt, e0 = err_cnt;
        logic [7:0] q[$];
        frame_bytes(v, q);
        foreach (q[i]) send(q[i]);
        repeat (3) @(negedge clk);
        chk({name, " bits"}, 32'(config_bits), 32'(v.e_bits));
        chk({name, " use_ff"}, 32'(use_ff), 32'(v.e_ff));
        chk({name, " loaded"}, 32'(cfg_loaded), 32'd1);
        chk({name, " done"}, done_cnt - d0, 32'(v.e_done));
        chk({name, " error"}, err_cnt - e0, 32'(v.e_err));
    endtask
    task automatic check_zero(input string name);
        chk({name, " bits"}, 32'(config_bits), 32'd0);
        chk({name, " use_ff"}, 32'(use_ff), 32'd0);
        chk({name, " loaded"}, 32'(cfg_loaded), 32'd0);
        chk({name, " done"}, 32'(cfg_done), 32'd0);
        chk({name, " error"}, 32'(cfg_error), 32'd0);
        chk({name, " ready"}, 32'(bus.cfg_ready), 32'd0);
    endtask
    vec_t tbl [6];
    initial begin
        logic [7:0] q[$];
        int d0, e0, cyc;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 8'h00;
        bus.cfg_abort = 1'b0;
        tbl[0] = '{4'd5, 64'hA5_00_00_80_01_00_00_00, 1'b0, 24'h800000, 1'b1, 2'd1, 2'd0};
        tbl[1] = '{4'd7, 64'h12_34_A5_FF_00_00_00_00, 1'b0, 24'h0000FF, 1'b0, 2'd1, 2'd0};
        tbl[2] = '{4'd5, 64'hA5_11_22_33_02_00_00_00, 1'b0, 24'h0000FF, 1'b0, 2'd0, 2'd1};
`ifdef CFG_LOADER_CHECKSUM_EN
        tbl[3] = '{4'd5, 64'hA5_11_22_33_01_00_00_00, 1'b1, 24'h0000FF, 1'b0, 2'd0, 2'd1};
`else
        tbl[3] = '{4'd5, 64'hA5_11_22_33_01_00_00_00, 1'b1, 24'h332211, 1'b1, 2'd1, 2'd0};
`endif
        tbl[4] = '{4'd5, 64'hA5_A5_A5_A5_00_00_00_00, 1'b0, 24'hA5A5A5, 1'b0, 2'd1, 2'd0};
        tbl[5] = '{4'd5, 64'hA5_5A_C3_3C_01_00_00_00, 1'b0, 24'h3CC35A, 1'b1, 2'd1, 2'd0};
        repeat (2) @(negedge clk);
        check_zero("in reset");
        rst_n = 1'b1;
        #1 chk("ready before edge", 32'(bus.cfg_ready), 32'd0);
        @(negedge clk);
        chk("ready after edge", 32'(bus.cfg_ready), 32'd1);
        chk("loaded after reset", 32'(cfg_loaded), 32'd0);
        for (int i = 0; i < 6; i++) apply(tbl[i], $sformatf("vec%0d", i));
        // abort alone after payload byte 1, trailing bytes must be dropped in IDLE
        d0 = done_cnt; e0 = err_cnt;
        send(8'hA5); send(8'h10); send(8'h20);
        @(negedge clk);
        bus.cfg_abort = 1'b1;
        @(negedge clk);
        bus.cfg_abort = 1'b0;
        send(8'h30); send(8'h01); send(8'h31);
        // abort on the same edge as an accepted byte
        send(8'hA5); send(8'h10);
        @(negedge clk);
        bus.cfg_valid = 1'b1; bus.cfg_data = 8'h20; bus.cfg_abort = 1'b1;
        @(negedge clk);
        bus.cfg_valid = 1'b0; bus.cfg_abort = 1'b0;
        send(8'h30); send(8'h00); send(8'h30);
        repeat (3) @(negedge clk);
        chk("abort bits", 32'(config_bits), 32'h3CC35A);
        chk("abort use_ff", 32'(use_ff), 32'd1);
        chk("abort done", done_cnt - d0, 32'd0);
        chk("abort error", err_cnt - e0, 32'd0);
        apply('{4'd5, 64'hA5_01_02_03_00_00_00_00, 1'b0, 24'h030201, 1'b0, 2'd1, 2'd0}, "post abort");
        // two frames streamed with valid held high
        d0 = done_cnt; e0 = err_cnt; cyc = 0;
        frame_bytes('{4'd5, 64'hA5_12_34_56_01_00_00_00, 1'b0, 24'h0, 1'b0, 2'd0, 2'd0}, q);
        frame_bytes('{4'd5, 64'hA5_AB_CD_EF_00_00_00_00, 1'b0, 24'h0, 1'b0, 2'd0, 2'd0}, q);
        @(negedge clk);
        win = 1'b1;
        foreach (q[i]) begin
            while (!bus.cfg_ready && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = q[i];
            @(negedge clk);
            cyc++;
        end
        bus.cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        win = 1'b0;
        chk("b2b cycles", cyc, 2*FL + 1);
        chk("b2b done", done_cnt - d0, 32'd2);
        chk("b2b ready low", low_cnt, 32'd2);
        chk("b2b error", err_cnt - e0, 32'd0);
        chk("b2b bits", 32'(config_bits), 32'hEFCDAB);
        chk("b2b use_ff", 32'(use_ff), 32'd0);
        // reset in the middle of a frame
        d0 = done_cnt; e0 = err_cnt;
        send(8'hA5); send(8'h10); send(8'h20);
        rst_n = 1'b0;
        #1 check_zero("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid reset done", done_cnt - d0, 32'd0);
        chk("mid reset error", err_cnt - e0, 32'd0);
        apply('{4'd5, 64'hA5_77_66_55_01_00_00_00, 1'b0, 24'h556677, 1'b1, 2'd1, 2'd0}, "post reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
